// File: rtl/mem_bus_responder.sv
// mem_bus_responder: byte-serial memory responder for an 8-bit core bus.
// Two-byte (high first) PC / MAR / MDR values arrive on core_bus; a PC
// triggers a 4-byte instruction fetch, MAR without MDR a 2-byte load, and
// MAR followed by MDR a store. A host preload port writes memory directly.
// Optional build macro RESP_STATS_EN enables saturating transaction counters.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a PC or MAR high byte
// PC_LO     | PC high byte held, expecting PC low byte
// MAR_LO    | MAR high byte held, expecting MAR low byte
// ADDR_WAIT | MAR complete; MDR high byte means store, no select means load
// MDR_LO    | data high byte held, expecting data low byte (store commits)
// SEND      | streaming fetch (4) or load (2) bytes back on in_bus
module mem_bus_responder #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  core_bus,
    input  logic        bus_pc,
    input  logic        bus_mar,
    input  logic        bus_mdr,
    input  logic        halt,
    output logic [7:0]  in_bus,
    output logic        ard_data_ready,
    output logic        ard_receive_ready,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        proto_err,
    output logic [15:0] fetch_cnt,
    output logic [15:0] load_cnt,
    output logic [15:0] store_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PC_LO,
        MAR_LO,
        ADDR_WAIT,
        MDR_LO,
        SEND
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [15:0]    mem [DEPTH];

    logic [15:0]    pc_q;
    logic [15:0]    mar_q;
    logic [7:0]     dat_hi_q;
    logic           is_fetch_q;
    logic [1:0]     send_left;
    logic           rst_done;

    logic [2:0]     sel;
    logic           ld_pc_hi;
    logic           ld_pc_lo;
    logic           ld_mar_hi;
    logic           ld_mar_lo;
    logic           ld_dat_hi;
    logic           store_commit;
    logic           start_fetch;
    logic           start_load;
    logic           set_err;

    logic [1:0]     byte_idx;
    logic [15:0]    rd_addr;
    logic [15:0]    rd_word;
    logic           unused_bits;

    assign sel = {bus_pc, bus_mar, bus_mdr};

    // State register; reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and capture/commit strobes. Halt overrides everything
    // without flagging an error; sampling is suppressed until the first edge
    // after reset release.
    always_comb begin
        state_nxt    = state;
        ld_pc_hi     = 1'b0;
        ld_pc_lo     = 1'b0;
        ld_mar_hi    = 1'b0;
        ld_mar_lo    = 1'b0;
        ld_dat_hi    = 1'b0;
        store_commit = 1'b0;
        start_fetch  = 1'b0;
        start_load   = 1'b0;
        set_err      = 1'b0;
        if (halt) begin
            state_nxt = IDLE;
        end else if (rst_done) begin
            case (state)
                IDLE: begin
                    if (sel == 3'b100) begin
                        ld_pc_hi  = 1'b1;
                        state_nxt = PC_LO;
                    end else if (sel == 3'b010) begin
                        ld_mar_hi = 1'b1;
                        state_nxt = MAR_LO;
                    end else if (sel != 3'b000) begin
                        set_err   = 1'b1;
                    end
                end
                PC_LO: begin
                    if (sel == 3'b100) begin
                        ld_pc_lo    = 1'b1;
                        start_fetch = 1'b1;
                        state_nxt   = SEND;
                    end else begin
                        set_err   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                MAR_LO: begin
                    if (sel == 3'b010) begin
                        ld_mar_lo = 1'b1;
                        state_nxt = ADDR_WAIT;
                    end else begin
                        set_err   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                ADDR_WAIT: begin
                    if (sel == 3'b001) begin
                        ld_dat_hi = 1'b1;
                        state_nxt = MDR_LO;
                    end else if (sel == 3'b000) begin
                        start_load = 1'b1;
                        state_nxt  = SEND;
                    end else begin
                        set_err   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                MDR_LO: begin
                    if (sel == 3'b001) begin
                        store_commit = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                SEND: begin
                    if (send_left == 2'd0) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Address/data capture, send down-counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rst_done   <= 1'b0;
            pc_q       <= '0;
            mar_q      <= '0;
            dat_hi_q   <= '0;
            is_fetch_q <= 1'b0;
            send_left  <= '0;
            proto_err  <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (ld_pc_hi)  pc_q[15:8]  <= core_bus;
            if (ld_pc_lo)  pc_q[7:0]   <= core_bus;
            if (ld_mar_hi) mar_q[15:8] <= core_bus;
            if (ld_mar_lo) mar_q[7:0]  <= core_bus;
            if (ld_dat_hi) dat_hi_q    <= core_bus;
            if (start_fetch) begin
                is_fetch_q <= 1'b1;
                send_left  <= 2'd3;
            end else if (start_load) begin
                is_fetch_q <= 1'b0;
                send_left  <= 2'd1;
            end else if (state == SEND && send_left != 2'd0) begin
                send_left  <= send_left - 2'd1;
            end
            if (set_err) proto_err <= 1'b1;
        end
    end

    // Memory write port: a core store beats a same-edge host preload. Memory
    // is never cleared, and a store landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (store_commit && rst) begin
            mem[mar_q[AW-1:0]] <= {dat_hi_q, core_bus};
        end else if (ld_we) begin
            mem[ld_addr[AW-1:0]] <= ld_data;
        end
    end

    // Read side: byte position within the burst counts up as send_left
    // counts down; bit 1 selects the second word of a fetch.
    assign byte_idx = (is_fetch_q ? 2'd3 : 2'd1) - send_left;
    assign rd_addr  = (is_fetch_q ? pc_q : mar_q) + {15'd0, byte_idx[1]};
    assign rd_word  = mem[rd_addr[AW-1:0]];

    assign ard_data_ready    = (state == SEND);
    assign ard_receive_ready = rst_done && (state != SEND);
    assign in_bus            = ard_data_ready ? (byte_idx[0] ? rd_word[7:0] : rd_word[15:8]) : 8'h00;

    // Address bits above the memory index are intentionally ignored.
    assign unused_bits = ^{rd_addr, ld_addr};

`ifdef RESP_STATS_EN
    // Saturating transaction counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt <= '0;
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if (start_fetch && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
            if (start_load && load_cnt != 16'hFFFF)   load_cnt  <= load_cnt + 16'd1;
            if (store_commit && store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
        end
    end
`else
    assign fetch_cnt = 16'h0000;
    assign load_cnt  = 16'h0000;
    assign store_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed plus randomized transactions against a
// word-array reference memory and transaction-level counters.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  core_bus = 8'h00;
    logic        bus_pc = 1'b0;
    logic        bus_mar = 1'b0;
    logic        bus_mdr = 1'b0;
    logic        halt = 1'b0;
    logic [7:0]  in_bus;
    logic        ard_data_ready;
    logic        ard_receive_ready;
    logic        ld_we = 1'b0;
    logic [15:0] ld_addr = 16'h0000;
    logic [15:0] ld_data = 16'h0000;
    logic        proto_err;
    logic [15:0] fetch_cnt;
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;

`ifdef RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    mem_bus_responder #(.DEPTH(256)) dut (
        .clk               (clk),
        .rst               (rst),
        .core_bus          (core_bus),
        .bus_pc            (bus_pc),
        .bus_mar           (bus_mar),
        .bus_mdr           (bus_mdr),
        .halt              (halt),
        .in_bus            (in_bus),
        .ard_data_ready    (ard_data_ready),
        .ard_receive_ready (ard_receive_ready),
        .ld_we             (ld_we),
        .ld_addr           (ld_addr),
        .ld_data           (ld_data),
        .proto_err         (proto_err),
        .fetch_cnt         (fetch_cnt),
        .load_cnt          (load_cnt),
        .store_cnt         (store_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [15:0] ref_mem [256];
    int          err_exp = 0;
    int          exp_fetch = 0;
    int          exp_load = 0;
    int          exp_store = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic drv(input logic [2:0] s, input logic [7:0] b);
        {bus_pc, bus_mar, bus_mdr} = s;
        core_bus = b;
    endtask

    function automatic int widx(input int a);
        return a % 256;
    endfunction

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return 16'($urandom);
        return {8'($urandom), 5'd0, 3'($urandom)};
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_rdy"},   32'(ard_data_ready), 0);
        chk({tag, "_bus"},   32'(in_bus), 0);
        chk({tag, "_rx"},    32'(ard_receive_ready), 1);
        chk({tag, "_err"},   32'(proto_err), err_exp);
        chk({tag, "_fcnt"},  32'(fetch_cnt), STATS ? exp_fetch : 0);
        chk({tag, "_lcnt"},  32'(load_cnt),  STATS ? exp_load  : 0);
        chk({tag, "_scnt"},  32'(store_cnt), STATS ? exp_store : 0);
    endtask

    // Called at the negedge after a reset edge; resets the model too.
    task automatic check_reset(input string tag);
        err_exp = 0; exp_fetch = 0; exp_load = 0; exp_store = 0;
        chk({tag, "_rdy"},  32'(ard_data_ready), 0);
        chk({tag, "_bus"},  32'(in_bus), 0);
        chk({tag, "_rx"},   32'(ard_receive_ready), 0);
        chk({tag, "_err"},  32'(proto_err), 0);
        chk({tag, "_cnt"},  32'({fetch_cnt | load_cnt | store_cnt}), 0);
    endtask

    task automatic expect_send(input logic [15:0] w0, input logic [15:0] w1,
                               input int n, input int halt_at);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            nxt();
            w = (i < 2) ? w0 : w1;
            chk("send_rdy",  32'(ard_data_ready), 1);
            chk("send_byte", 32'(in_bus), 32'((i % 2 == 0) ? w[15:8] : w[7:0]));
            chk("send_rx",   32'(ard_receive_ready), 0);
            if (i == halt_at) begin
                drv(3'b000, 8'h00);
                halt = 1'b1;
                break;
            end
            drv(3'($urandom), 8'($urandom));
        end
        nxt();
        halt = 1'b0;
        check_idle("post_send");
        drv(3'b000, 8'h00);
    endtask

    task automatic do_fetch(input logic [15:0] pc, input int halt_at);
        nxt(); drv(3'b100, pc[15:8]);
        nxt(); chk("pc_lo_rx", 32'(ard_receive_ready), 1); drv(3'b100, pc[7:0]);
        if (exp_fetch < 65535) exp_fetch++;
        expect_send(ref_mem[widx(int'(pc))], ref_mem[widx(int'(pc) + 1)], 4, halt_at);
    endtask

    task automatic do_load(input logic [15:0] a);
        nxt(); drv(3'b010, a[15:8]);
        nxt(); drv(3'b010, a[7:0]);
        nxt();
        chk("aw_rdy", 32'(ard_data_ready), 0);
        chk("aw_rx",  32'(ard_receive_ready), 1);
        drv(3'b000, 8'($urandom));
        if (exp_load < 65535) exp_load++;
        expect_send(ref_mem[widx(int'(a))], 16'h0000, 2, -1);
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d,
                            input bit clash, input logic [15:0] la, input logic [15:0] ld);
        nxt(); drv(3'b010, a[15:8]);
        nxt(); drv(3'b010, a[7:0]);
        nxt(); drv(3'b001, d[15:8]);
        nxt(); drv(3'b001, d[7:0]);
        if (clash) begin ld_we = 1'b1; ld_addr = la; ld_data = ld; end
        ref_mem[widx(int'(a))] = d;
        if (exp_store < 65535) exp_store++;
        nxt(); ld_we = 1'b0; drv(3'b000, 8'h00);
        check_idle("store");
    endtask

    task automatic host_write(input logic [15:0] a, input logic [15:0] d);
        nxt(); ld_we = 1'b1; ld_addr = a; ld_data = d;
        ref_mem[widx(int'(a))] = d;
        nxt(); ld_we = 1'b0;
        check_idle("host");
    endtask

    task automatic do_error(input int kind);
        logic [15:0] a;
        a = rand_addr();
        nxt();
        case (kind)
            0: begin drv(3'b100, a[15:8]); nxt(); drv(3'b010, a[7:0]); end
            1: drv(3'b001, a[15:8]);
            2: drv(3'b110, a[15:8]);
            3: begin
                drv(3'b010, a[15:8]); nxt(); drv(3'b010, a[7:0]);
                nxt(); drv(3'b100, 8'($urandom));
            end
            4: begin
                drv(3'b010, a[15:8]); nxt(); drv(3'b010, a[7:0]);
                nxt(); drv(3'b001, 8'($urandom)); nxt(); drv(3'b000, 8'($urandom));
            end
            default: begin drv(3'b010, a[15:8]); nxt(); drv(3'b000, a[7:0]); end
        endcase
        err_exp = 1;
        nxt(); check_idle("err"); drv(3'b000, 8'h00);
    endtask

    task automatic do_reset();
        nxt(); rst = 1'b0; drv(3'b000, 8'h00);
        nxt(); check_reset("rst"); rst = 1'b1;
        nxt(); check_idle("rst_rel");
    endtask

    // Halt or reset in the middle of a capture: no error, no write.
    task automatic do_abort(input int kind);
        logic [15:0] a;
        a = rand_addr();
        nxt();
        if (kind == 0) begin
            drv(3'b100, a[15:8]); nxt(); drv(3'b100, a[7:0]); halt = 1'b1;
            nxt(); halt = 1'b0; check_idle("halt_pc"); drv(3'b000, 8'h00);
        end else begin
            drv(3'b010, a[15:8]); nxt(); drv(3'b010, a[7:0]);
            nxt(); drv(3'b001, 8'($urandom)); nxt(); drv(3'b001, 8'($urandom));
            if (kind == 1) begin
                halt = 1'b1;
                nxt(); halt = 1'b0; check_idle("halt_st"); drv(3'b000, 8'h00);
            end else begin
                rst = 1'b0;
                nxt(); drv(3'b000, 8'h00); check_reset("rst_st"); rst = 1'b1;
                nxt(); check_idle("rst_st_rel");
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        repeat (3) nxt();
        check_reset("por");
        rst = 1'b1;
        nxt(); check_idle("por_rel");

        for (int i = 0; i < 256; i++) begin
            ld_we = 1'b1; ld_addr = 16'(i); ld_data = 16'($urandom);
            ref_mem[i] = ld_data;
            nxt();
        end
        ld_we = 1'b0;
        nxt(); check_idle("preload");

        host_write(16'h0005, 16'h1234);
        host_write(16'h0006, 16'hABCD);
        do_fetch(16'h0005, -1);

        do_store(16'h0010, 16'hBEEF, 1'b0, 16'h0000, 16'h0000);
        do_load(16'h0010);

        do_fetch(16'h01FF, -1);

        do_error(0);
        do_fetch(16'h0005, -1);
        do_reset();

        do_fetch(16'h0005, 1);

        host_write(16'h0003, 16'h0000);
        do_store(16'h0003, 16'h5555, 1'b1, 16'h0003, 16'hAAAA);
        do_load(16'h0003);

        for (int it = 0; it < 250; it++) begin
            r = int'($urandom_range(0, 19));
            if (r < 4)       do_fetch(rand_addr(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
            else if (r < 8)  do_load(rand_addr());
            else if (r < 12) do_store(rand_addr(), 16'($urandom), 1'($urandom), rand_addr(), 16'($urandom));
            else if (r < 14) host_write(rand_addr(), 16'($urandom));
            else if (r < 16) do_error(int'($urandom_range(0, 5)));
            else if (r < 18) do_abort(int'($urandom_range(0, 2)));
            else if (r < 19) begin
                repeat (int'($urandom_range(1, 3))) begin nxt(); check_idle("gap"); end
            end
            else             do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
